prefsize_ctr: RTL and testbench

Parametrised prefetch transfer-size counter for the Tom prefetch path. It loads a transfer length, then decrements it by a variable step (0..2^STEP_W-1) on each accepted consume strobe, and signals completion and underflow. It supersedes the fixed 23-bit, 3-bit-step combinational size subtractor with a registered counter that has load, abort and done handshakes. The prefetch queue controller owns the block and uses it to decide when to stop issuing fetches.

---
 rtl/prefsize_pkg.sv | 14 +
 rtl/prefsize_dec.sv | 71 +++++++
 rtl/prefsize_ctr.sv | 114 +++++++++++
 tb/tb_prefsize_ctr.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/prefsize_pkg.sv
// Shared types and default sizing for the prefetch transfer-size counter.
// Saturating underflow is selected at build time with PREFSIZE_SAT_EN.
package prefsize_pkg;

   localparam int PS_WIDTH  = 23;
   localparam int PS_STEP_W = 3;
   localparam int PS_GROUP  = 7;

   typedef enum logic [0:0] {
      PS_IDLE = 1'b0,
      PS_RUN  = 1'b1
   } ps_state_e;

endpackage

// File: rtl/prefsize_dec.sv
// Combinational WIDTH-bit minus zero-extended STEP_W-bit decrementer built from
// GROUP-bit ripple groups joined by a carry-skip borrow chain.
module prefsize_dec
   import prefsize_pkg::*;
#(
   parameter int WIDTH  = PS_WIDTH,
   parameter int STEP_W = PS_STEP_W,
   parameter int GROUP  = PS_GROUP
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [STEP_W-1:0] b,
   output logic [WIDTH-1:0]  diff,
   output logic              borrow
);

   localparam int NG = (WIDTH + GROUP - 1) / GROUP;

   logic [WIDTH-1:0] b_ext_s;

   assign b_ext_s = {{(WIDTH - STEP_W){1'b0}}, b};

   for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int LO = g * GROUP;
      localparam int HI = ((LO + GROUP) > WIDTH) ? WIDTH : (LO + GROUP);
      localparam int N  = HI - LO;

      logic [N-1:0] a_grp_s;
      logic [N-1:0] b_grp_s;
      logic [N-1:0] x_grp_s;
      logic [N-1:0] d_grp_s;
      logic         bin_s;
      logic         bout_s;
      logic         gen_s;
      logic         skip_s;

      if (g == 0) begin : g_first
         assign bin_s = 1'b0;
      end else begin : g_next
         assign bin_s = g_grp[g-1].bout_s;
      end

      assign a_grp_s = a[HI-1:LO];
      assign b_grp_s = b_ext_s[HI-1:LO];
      assign x_grp_s = a_grp_s ^ b_grp_s;

      // Ripple the real borrow for the difference bits, and in parallel the
      // borrow this group generates on its own (borrow-in forced to zero).
      always_comb begin : ripple
         logic rip_s;
         logic gacc_s;
         d_grp_s = {N{1'b0}};
         rip_s   = bin_s;
         gacc_s  = 1'b0;
         for (int i = 0; i < N; i++) begin
            d_grp_s[i] = x_grp_s[i] ^ rip_s;
            rip_s      = (~a_grp_s[i] & b_grp_s[i]) | (~x_grp_s[i] & rip_s);
            gacc_s     = (~a_grp_s[i] & b_grp_s[i]) | (~x_grp_s[i] & gacc_s);
         end
         gen_s = gacc_s;
      end

      // When every bit pair matches, the incoming borrow passes straight through.
      assign skip_s = ~|x_grp_s;
      assign bout_s = skip_s ? bin_s : gen_s;

      assign diff[HI-1:LO] = d_grp_s;
   end

   assign borrow = g_grp[NG-1].bout_s;

endmodule

// File: rtl/prefsize_ctr.sv
// Registered prefetch transfer-size counter with load, abort, done and underflow.
// Build option PREFSIZE_SAT_EN: oversize decrements saturate to zero instead of wrapping.
module prefsize_ctr
   import prefsize_pkg::*;
#(
   parameter int WIDTH  = PS_WIDTH,
   parameter int STEP_W = PS_STEP_W,
   parameter int GROUP  = PS_GROUP
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              ld,
   input  logic [WIDTH-1:0]  ld_val,
   input  logic              dec,
   input  logic [STEP_W-1:0] dec_amt,
   input  logic              abort,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              under,
   output logic [STEP_W-1:0] taken
);

   ps_state_e        state_r;
   logic [WIDTH-1:0] diff_s;
   logic             borrow_s;
   logic             zero_s;

   prefsize_dec #(
      .WIDTH  (WIDTH),
      .STEP_W (STEP_W),
      .GROUP  (GROUP)
   ) u_dec (
      .a      (count),
      .b      (dec_amt),
      .diff   (diff_s),
      .borrow (borrow_s)
   );

   assign zero_s = (diff_s == {WIDTH{1'b0}});

   // Control FSM and all output registers; ld outranks abort, abort outranks dec.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_r <= PS_IDLE;
         count   <= {WIDTH{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         under   <= 1'b0;
         taken   <= {STEP_W{1'b0}};
      end else begin
         done <= 1'b0;
         if (ld) begin
            count <= ld_val;
            under <= 1'b0;
            if (ld_val != {WIDTH{1'b0}}) begin
               state_r <= PS_RUN;
               busy    <= 1'b1;
            end else begin
               state_r <= PS_IDLE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
         end else if (abort) begin
            state_r <= PS_IDLE;
            busy    <= 1'b0;
         end else begin
            case (state_r)
               PS_IDLE: begin
                  state_r <= PS_IDLE;
               end
               PS_RUN: begin
                  if (dec) begin
                     if (!borrow_s) begin
                        count <= diff_s;
                        taken <= dec_amt;
                        if (zero_s) begin
                           done    <= 1'b1;
                           state_r <= PS_IDLE;
                           busy    <= 1'b0;
                        end else begin
                           state_r <= PS_RUN;
                        end
                     end else begin
`ifdef PREFSIZE_SAT_EN
                        // Only what was left can be removed; the remainder is lost.
                        count   <= {WIDTH{1'b0}};
                        taken   <= count[STEP_W-1:0];
                        under   <= 1'b1;
                        done    <= 1'b1;
                        state_r <= PS_IDLE;
                        busy    <= 1'b0;
`else
                        // Wrapped value stays in RUN; the owner is expected to abort.
                        count   <= diff_s;
                        taken   <= dec_amt;
                        under   <= 1'b1;
                        state_r <= PS_RUN;
`endif
                     end
                  end else begin
                     state_r <= PS_RUN;
                  end
               end
               default: begin
                  state_r <= PS_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prefsize_ctr.sv
// Self-checking bench for prefsize_ctr: directed cases with literal expectations
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_prefsize_ctr;

   localparam int W  = 23;
   localparam int SW = 3;
   localparam int G  = 7;

   logic          sys_clk = 1'b0;
   logic          reset;
   logic          ld;
   logic [W-1:0]  ld_val;
   logic          dec;
   logic [SW-1:0] dec_amt;
   logic          abort;
   logic [W-1:0]  count;
   logic          busy;
   logic          done;
   logic          under;
   logic [SW-1:0] taken;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   longint m_cnt   = 0;
   bit     m_run   = 1'b0;
   bit     m_done  = 1'b0;
   bit     m_under = 1'b0;
   int     m_taken = 0;

   always #5 sys_clk = ~sys_clk;

   prefsize_ctr #(.WIDTH(W), .STEP_W(SW), .GROUP(G)) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .ld      (ld),
      .ld_val  (ld_val),
      .dec     (dec),
      .dec_amt (dec_amt),
      .abort   (abort),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .under   (under),
      .taken   (taken)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference behaviour computed from plain integer arithmetic on the inputs.
   always @(posedge sys_clk) begin
      longint mask;
      longint amt;
      mask   = (longint'(1) << W) - 1;
      amt    = longint'(dec_amt);
      m_done = 1'b0;
      if (reset) begin
         m_cnt = 0; m_run = 1'b0; m_under = 1'b0; m_taken = 0;
      end else if (ld) begin
         m_cnt   = longint'(ld_val);
         m_under = 1'b0;
         m_run   = (m_cnt != 0);
         m_done  = (m_cnt == 0);
      end else if (abort) begin
         m_run = 1'b0;
      end else if (dec && m_run) begin
         if (amt <= m_cnt) begin
            m_cnt   = m_cnt - amt;
            m_taken = int'(amt);
            if (m_cnt == 0) begin
               m_done = 1'b1;
               m_run  = 1'b0;
            end
         end else begin
`ifdef PREFSIZE_SAT_EN
            m_taken = int'(m_cnt);
            m_cnt   = 0;
            m_under = 1'b1;
            m_done  = 1'b1;
            m_run   = 1'b0;
`else
            m_cnt   = (m_cnt - amt) & mask;
            m_taken = int'(amt);
            m_under = 1'b1;
`endif
         end
      end
   end

   always @(negedge sys_clk) begin
      if (chk_en) begin
         chk("model_count", 64'(count), 64'(m_cnt));
         chk("model_busy",  64'(busy),  64'(m_run));
         chk("model_done",  64'(done),  64'(m_done));
         chk("model_under", 64'(under), 64'(m_under));
         chk("model_taken", 64'(taken), 64'(m_taken));
      end
   end

   // Apply one cycle of inputs just after a falling edge; returns at the next falling edge.
   task automatic drive(input bit l, input longint lv, input bit d, input int a, input bit ab);
      ld      = l;
      ld_val  = lv[W-1:0];
      dec     = d;
      dec_amt = a[SW-1:0];
      abort   = ab;
      @(negedge sys_clk);
   endtask

   initial begin
      reset = 1'b1; ld = 1'b0; ld_val = '0; dec = 1'b0; dec_amt = '0; abort = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      chk_en = 1'b1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_busy",  64'(busy),  64'd0);
      chk("rst_done",  64'(done),  64'd0);
      chk("rst_under", 64'(under), 64'd0);
      chk("rst_taken", 64'(taken), 64'd0);
      reset = 1'b0;

      drive(1, 10, 0, 0, 0);
      chk("ld10_count", 64'(count), 64'd10);
      chk("ld10_busy",  64'(busy),  64'd1);
      drive(0, 0, 1, 3, 0);
      chk("dec3_count", 64'(count), 64'd7);
      chk("dec3_taken", 64'(taken), 64'd3);
      drive(0, 0, 1, 3, 0);
      chk("dec3b_count", 64'(count), 64'd4);
      drive(0, 0, 1, 3, 0);
      chk("dec3c_count", 64'(count), 64'd1);
      drive(0, 0, 1, 1, 0);
      chk("last_count", 64'(count), 64'd0);
      chk("last_done",  64'(done),  64'd1);
      chk("last_busy",  64'(busy),  64'd0);
      chk("last_under", 64'(under), 64'd0);

      drive(1, 6, 0, 0, 0);
      chk("b2b_count", 64'(count), 64'd6);
      chk("b2b_busy",  64'(busy),  64'd1);
      chk("b2b_done",  64'(done),  64'd0);
      drive(0, 0, 1, 0, 0);
      chk("zero_amt_count", 64'(count), 64'd6);
      chk("zero_amt_taken", 64'(taken), 64'd0);
      chk("zero_amt_done",  64'(done),  64'd0);
      drive(0, 0, 0, 0, 1);
      chk("abort_count", 64'(count), 64'd6);
      chk("abort_busy",  64'(busy),  64'd0);
      chk("abort_done",  64'(done),  64'd0);
      drive(0, 0, 1, 2, 0);
      chk("idle_dec_count", 64'(count), 64'd6);
      chk("idle_dec_taken", 64'(taken), 64'd0);

      drive(1, 64'h7FFFF0, 0, 0, 0);
      drive(0, 0, 1, 7, 0);
      chk("grp_count", 64'(count), 64'h7FFFE9);
      drive(1, 64'h80, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      chk("grp1_count", 64'(count), 64'h7F);
      drive(1, 64'h400000, 0, 0, 0);
      drive(0, 0, 1, 1, 0);
      chk("skip_count", 64'(count), 64'h3FFFFF);

      drive(1, 0, 0, 0, 0);
      chk("ld0_count", 64'(count), 64'd0);
      chk("ld0_busy",  64'(busy),  64'd0);
      chk("ld0_done",  64'(done),  64'd1);
      drive(0, 0, 0, 0, 0);
      chk("ld0_done_drop", 64'(done), 64'd0);

      drive(1, 8, 0, 0, 0);
      drive(1, 4, 1, 1, 1);
      chk("prio_count", 64'(count), 64'd4);
      chk("prio_busy",  64'(busy),  64'd1);

      drive(1, 2, 0, 0, 0);
      drive(0, 0, 1, 5, 0);
`ifdef PREFSIZE_SAT_EN
      chk("under_count", 64'(count), 64'd0);
      chk("under_taken", 64'(taken), 64'd2);
      chk("under_flag",  64'(under), 64'd1);
      chk("under_done",  64'(done),  64'd1);
      chk("under_busy",  64'(busy),  64'd0);
`else
      chk("under_count", 64'(count), 64'h7FFFFD);
      chk("under_taken", 64'(taken), 64'd5);
      chk("under_flag",  64'(under), 64'd1);
      chk("under_busy",  64'(busy),  64'd1);
      chk("under_done",  64'(done),  64'd0);
`endif

      reset = 1'b1;
      drive(0, 0, 1, 1, 0);
      reset = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_under", 64'(under), 64'd0);
      chk("mid_rst_busy",  64'(busy),  64'd0);
      chk("mid_rst_taken", 64'(taken), 64'd0);

      for (int k = 0; k < 4000; k++) begin
         longint lv;
         reset = ($urandom_range(0, 599) == 0);
         lv = ($urandom_range(0, 3) == 0) ? longint'($urandom) : longint'($urandom_range(0, 24));
         drive(($urandom_range(0, 11) == 0), lv, ($urandom_range(0, 2) != 0),
               int'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
      end
      reset = 1'b0;
      drive(0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
